// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential shift-add-3 (double-dabble) converter from a
//                signed two's-complement value to DIGITS BCD digits plus a
//                display flag for the seven-segment digit decoders.
//                One magnitude bit is consumed per clock; start/busy/done
//                handshake with a fixed latency of IN_W+2 cycles from the
//                accepting edge to the done pulse.
//
//  Parameters  : IN_W    - width of the signed input value
//                DIGITS  - number of BCD output digits (DIGITS-1 leftmost)
//
//  Ports       : clk       in   system clock, rising edge
//                rst       in   synchronous active-high reset
//                start     in   conversion request, sampled only in IDLE
//                value_in  in   signed operand, captured on accepted start
//                busy      out  high from the cycle after accept until done
//                done      out  one-cycle pulse when outputs update
//                bcd_out   out  digit i at [4i+3:4i], digit 0 least significant
//                flag      out  1 non-negative, 2 negative, 0 overflow
//                blank     out  per-digit leading-zero blank mask
//
//  Build macro : LEADING_ZERO_BLANK_EN - when defined, blank is computed and
//                registered at the end of each conversion; otherwise blank is
//                held at zero and no blanking logic exists.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       value_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [2:0]            flag,
    output logic [DIGITS-1:0]     blank
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [2:0] c_flag_ovf = 3'd0;
    localparam logic [2:0] c_flag_pos = 3'd1;
    localparam logic [2:0] c_flag_neg = 3'd2;

    localparam logic [IN_W-1:0]  c_one      = {{(IN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(IN_W);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int k = 0; k < n; k++) begin
            v = v * 64'd10;
        end
        return v;
    endfunction

    // Largest displayable magnitudes. A negative result loses the leftmost
    // digit to the minus sign, so it has one digit less of range.
    localparam logic [63:0] c_max_pos = pow10(DIGITS) - 64'd1;
    localparam logic [63:0] c_max_neg = pow10(DIGITS - 1) - 64'd1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [IN_W-1:0]   r_value;
    logic [IN_W-1:0]   r_mag;
    logic [BCD_W-1:0]  r_bcd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sign;
    logic              r_ovf;
    logic              r_busy;
    logic              r_done;
    logic [BCD_W-1:0]  r_bcd_out;
    logic [2:0]        r_flag;

    logic [IN_W-1:0]   w_abs;
    logic              w_ovf;
    logic [BCD_W-1:0]  w_bcd_adj;
    logic [BCD_W-1:0]  w_digits;

    // Magnitude of the captured value. The most negative input wraps back
    // to 2^(IN_W-1), which is exactly representable as unsigned IN_W bits.
    assign w_abs = r_value[IN_W-1] ? ((~r_value) + c_one) : r_value;

    assign w_ovf = r_value[IN_W-1] ? (64'(w_abs) > c_max_neg)
                                   : (64'(w_abs) > c_max_pos);

    // Add-3 correction applied to every nibble before each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5)
                                   ? (r_bcd[4*g +: 4] + 4'd3)
                                   : r_bcd[4*g +: 4];
    end

    // Converted digits with the leftmost digit cleared for negative results;
    // that position is rendered as the minus sign by the decoder.
    always_comb begin
        w_digits = r_bcd;
        if (r_sign) begin
            w_digits[BCD_W-1 -: 4] = 4'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_value   <= '0;
            r_mag     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd_out <= '0;
            r_flag    <= c_flag_pos;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_value <= value_in;
                        r_busy  <= 1'b1;
                        r_state <= c_st_load;
                    end
                end

                c_st_load: begin
                    r_sign  <= r_value[IN_W-1];
                    r_mag   <= w_abs;
                    r_ovf   <= w_ovf;
                    r_bcd   <= '0;
                    r_cnt   <= c_cnt_load;
                    r_state <= c_st_shift;
                end

                c_st_shift: begin
                    // Shift the corrected scratch and magnitude as one word.
                    {r_bcd, r_mag} <= {w_bcd_adj[BCD_W-2:0], r_mag, 1'b0};
                    r_cnt          <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= c_st_done;
                    end
                end

                c_st_done: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= c_st_idle;
                    if (r_ovf) begin
                        r_bcd_out <= '0;
                        r_flag    <= c_flag_ovf;
                    end else if (r_sign) begin
                        r_bcd_out <= w_digits;
                        r_flag    <= c_flag_neg;
                    end else begin
                        r_bcd_out <= w_digits;
                        r_flag    <= c_flag_pos;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd_out;
    assign flag    = r_flag;

    // ------------------------------------------------------------------------
    // Leading-zero blanking
    // ------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank;

    // Walk from the most significant usable digit towards digit 1 and blank
    // zeros until the first nonzero digit. The sign position is skipped for
    // negative results, and digit 0 always shows.
    always_comb begin
        logic lead;
        w_blank = '0;
        lead    = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (!(r_sign && (i == DIGITS - 1))) begin
                if (lead && (w_digits[4*i +: 4] == 4'd0)) begin
                    w_blank[i] = 1'b1;
                end else begin
                    lead = 1'b0;
                end
            end
        end
        if (r_ovf) begin
            w_blank = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blank <= '0;
        end else if (r_state == c_st_done) begin
            r_blank <= w_blank;
        end
    end

    assign blank = r_blank;
`else
    assign blank = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Self-checking bench for bin_to_bcd_seq. Expected results come
//                from an arithmetic reference model (division by ten, digit
//                counting); LEADING_ZERO_BLANK_EN selects the blank model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int IN_W   = 16;
    localparam int DIGITS = 4;
    localparam int LAT    = IN_W + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [IN_W-1:0]      value_in;
    logic                 busy;
    logic                 done;
    logic [4*DIGITS-1:0]  bcd_out;
    logic [2:0]           flag;
    logic [DIGITS-1:0]    blank;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value_in (value_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .flag     (flag),
        .blank    (blank)
    );

    function automatic int ipow10(input int n);
        int v = 1;
        for (int k = 0; k < n; k++) v = v * 10;
        return v;
    endfunction

    // Reference model: decimal conversion by plain arithmetic.
    task automatic model(input logic [IN_W-1:0] raw,
                         output logic [4*DIGITS-1:0] eb,
                         output logic [2:0] ef,
                         output logic [DIGITS-1:0] ebl);
        int v, mag, lim, t, nd;
        logic neg;
        v   = int'($signed(raw));
        neg = (v < 0);
        mag = neg ? -v : v;
        lim = neg ? ipow10(DIGITS - 1) - 1 : ipow10(DIGITS) - 1;
        eb  = '0;
        ebl = '0;
        if (mag > lim) begin
            ef = 3'd0;
        end else begin
            ef = neg ? 3'd2 : 3'd1;
            t  = mag;
            for (int i = 0; i < DIGITS; i++) begin
                eb[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
`ifdef LEADING_ZERO_BLANK_EN
            nd = 1;
            t  = mag / 10;
            while (t > 0) begin
                nd++;
                t = t / 10;
            end
            for (int i = 0; i < DIGITS; i++) begin
                if (i >= nd && !(neg && i == DIGITS - 1)) ebl[i] = 1'b1;
            end
`else
            nd = 0;
`endif
        end
    endtask

    // Drive one conversion and return what the DUT shows at its done pulse.
    task automatic convert(input logic [IN_W-1:0] v, output int lat,
                           output logic busy_acc, output logic busy_dn,
                           output logic [4*DIGITS-1:0] b, output logic [2:0] f,
                           output logic [DIGITS-1:0] bl);
        @(posedge clk); #1;
        start    = 1'b1;
        value_in = v;
        @(posedge clk); #1;
        start    = 1'b0;
        value_in = IN_W'($urandom);
        busy_acc = busy;
        lat = -1;
        for (int k = 1; k <= LAT + 10; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        busy_dn = busy;
        b  = bcd_out;
        f  = flag;
        bl = blank;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; value_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (bcd_out !== '0) begin n_err++; $display("FAIL reset_bcd got %h want 0", bcd_out); end
        n_vec++; if (flag !== 3'd1) begin n_err++; $display("FAIL reset_flag got %0d want 1", flag); end
        n_vec++; if (blank !== '0) begin n_err++; $display("FAIL reset_blank got %b want 0", blank); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [IN_W-1:0] vals [12];
        logic [4*DIGITS-1:0] b, eb;
        logic [2:0] f, ef;
        logic [DIGITS-1:0] bl, ebl;
        logic ba, bd;
        int lat;
        vals = '{16'(1234), 16'(-987), 16'(-7), 16'(10000), 16'(-1000),
                 16'(-32768), 16'(0), 16'(9999), 16'(-999), 16'(32767),
                 16'(1), 16'(5)};
        // Hand-checked anchor values from the reference model's rules.
        model(16'(1234), eb, ef, ebl);
        n_vec++; if (eb !== 16'h1234 || ef !== 3'd1) begin n_err++; $display("FAIL model_anchor got %h/%0d want 1234/1", eb, ef); end
        foreach (vals[j]) begin
            model(vals[j], eb, ef, ebl);
            convert(vals[j], lat, ba, bd, b, f, bl);
            n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL dir_latency v=%h got %0d want %0d", vals[j], lat, LAT); end
            n_vec++; if (ba !== 1'b1) begin n_err++; $display("FAIL dir_busy_accept v=%h got %b want 1", vals[j], ba); end
            n_vec++; if (bd !== 1'b0) begin n_err++; $display("FAIL dir_busy_done v=%h got %b want 0", vals[j], bd); end
            n_vec++; if (b !== eb) begin n_err++; $display("FAIL dir_bcd v=%h got %h want %h", vals[j], b, eb); end
            n_vec++; if (f !== ef) begin n_err++; $display("FAIL dir_flag v=%h got %0d want %0d", vals[j], f, ef); end
            n_vec++; if (bl !== ebl) begin n_err++; $display("FAIL dir_blank v=%h got %b want %b", vals[j], bl, ebl); end
            @(posedge clk); #1;
            n_vec++; if (done !== 1'b0 || bcd_out !== eb) begin n_err++; $display("FAIL dir_hold v=%h got done=%b bcd=%h want 0/%h", vals[j], done, bcd_out, eb); end
        end
    endtask

    task automatic test_random();
        logic [IN_W-1:0] v;
        logic [4*DIGITS-1:0] b, eb;
        logic [2:0] f, ef;
        logic [DIGITS-1:0] bl, ebl;
        logic ba, bd;
        int lat;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) v = IN_W'($urandom);
            else v = IN_W'(int'($urandom_range(0, 19998)) - 9999);
            model(v, eb, ef, ebl);
            convert(v, lat, ba, bd, b, f, bl);
            n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL rnd_latency v=%h got %0d want %0d", v, lat, LAT); end
            n_vec++; if (b !== eb || f !== ef) begin n_err++; $display("FAIL rnd_result v=%h got %h/%0d want %h/%0d", v, b, f, eb, ef); end
            n_vec++; if (bl !== ebl) begin n_err++; $display("FAIL rnd_blank v=%h got %b want %b", v, bl, ebl); end
        end
    endtask

    task automatic test_ignore_start();
        logic [4*DIGITS-1:0] eb, b;
        logic [2:0] ef, f;
        logic [DIGITS-1:0] ebl;
        int ndone, first;
        model(16'(321), eb, ef, ebl);
        b = '0; f = 3'd7; ndone = 0; first = -1;
        @(posedge clk); #1;
        start = 1'b1; value_in = 16'(321);
        @(posedge clk); #1;
        start = 1'b0; value_in = 16'(-45);
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            start = (k == 5);
            if (done) begin
                ndone++;
                if (first < 0) begin first = k; b = bcd_out; f = flag; end
            end
        end
        start = 1'b0;
        n_vec++; if (ndone !== 1) begin n_err++; $display("FAIL ign_done_count got %0d want 1", ndone); end
        n_vec++; if (first !== LAT) begin n_err++; $display("FAIL ign_latency got %0d want %0d", first, LAT); end
        n_vec++; if (b !== eb || f !== ef) begin n_err++; $display("FAIL ign_result got %h/%0d want %h/%0d", b, f, eb, ef); end
    endtask

    task automatic test_reset_mid();
        logic [4*DIGITS-1:0] b;
        logic [2:0] f;
        logic [DIGITS-1:0] bl;
        logic ba, bd;
        int lat, ndone;
        convert(16'(4321), lat, ba, bd, b, f, bl);
        @(posedge clk); #1;
        start = 1'b1; value_in = 16'(777);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_vec++; if (bcd_out !== '0) begin n_err++; $display("FAIL rstmid_bcd got %h want 0", bcd_out); end
        n_vec++; if (flag !== 3'd1) begin n_err++; $display("FAIL rstmid_flag got %0d want 1", flag); end
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            if (done || busy) ndone++;
            @(posedge clk); #1;
        end
        n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL rstmid_activity got %0d want 0", ndone); end
        convert(16'(42), lat, ba, bd, b, f, bl);
        n_vec++; if (b !== 16'h0042 || f !== 3'd1) begin n_err++; $display("FAIL rstmid_after got %h/%0d want 0042/1", b, f); end
        n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL rstmid_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_back_to_back();
        logic [4*DIGITS-1:0] ea, eb2;
        logic [2:0] fa, fb;
        logic [DIGITS-1:0] la, lb;
        int t1, t2;
        model(16'(-56), ea, fa, la);
        model(16'(8080), eb2, fb, lb);
        @(posedge clk); #1;
        start = 1'b1; value_in = 16'(-56);
        @(posedge clk); #1;
        value_in = 16'(8080);
        t1 = -1;
        for (int k = 1; k <= LAT + 10; k++) begin
            @(posedge clk); #1;
            if (done) begin t1 = k; break; end
        end
        n_vec++; if (t1 !== LAT) begin n_err++; $display("FAIL b2b_lat1 got %0d want %0d", t1, LAT); end
        n_vec++; if (bcd_out !== ea || flag !== fa || blank !== la) begin n_err++; $display("FAIL b2b_res1 got %h/%0d/%b want %h/%0d/%b", bcd_out, flag, blank, ea, fa, la); end
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
        t2 = -1;
        for (int k = 1; k <= LAT + 10; k++) begin
            @(posedge clk); #1;
            if (done) begin t2 = k; break; end
        end
        n_vec++; if (t2 !== LAT) begin n_err++; $display("FAIL b2b_lat2 got %0d want %0d", t2, LAT); end
        n_vec++; if (bcd_out !== eb2 || flag !== fb || blank !== lb) begin n_err++; $display("FAIL b2b_res2 got %h/%0d/%b want %h/%0d/%b", bcd_out, flag, blank, eb2, fb, lb); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; value_in = '0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
